floor_scheduler: RTL



---
 rtl/floor_pkg.sv | 38 +++
 rtl/floor_lfsr.sv | 30 +++
 rtl/floor_scheduler.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/floor_pkg.sv
// Shared types, screen constants and small helpers for the floor scheduler.
package floor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam int FLOOR_W    = 40;
    localparam int FLOOR_H    = 5;
    localparam int POS_W      = 10;
    localparam int NUM_FLOORS = 4;

    function automatic logic [2:0] popcount4(input logic [NUM_FLOORS-1:0] v);
        logic [2:0] c;
        c = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            c = c + {2'b00, v[i]};
        end
        return c;
    endfunction

    // Lowest-index slot whose enable bit is clear; only meaningful if one exists.
    function automatic logic [1:0] first_free(input logic [NUM_FLOORS-1:0] en);
        logic [1:0] idx;
        idx = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (!en[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/floor_lfsr.sv
// Free-running 10-bit Fibonacci LFSR folded into the spawn x range.
module floor_lfsr
    import floor_pkg::*;
#(
    parameter int XMAX = SCREEN_W - FLOOR_W
) (
    input  logic             clk,
    input  logic             rst,
    output logic [POS_W-1:0] spawn_x
);

    localparam logic [POS_W-1:0] XMAX_V = POS_W'(XMAX);

    logic [POS_W-1:0] lfsr_q;
    logic [POS_W-1:0] lfsr_d;

    assign lfsr_d = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= 10'h001;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // One subtraction suffices: 1023 - XMAX stays below XMAX.
    assign spawn_x = (lfsr_q >= XMAX_V) ? lfsr_q - XMAX_V : lfsr_q;

endmodule

// File: rtl/floor_scheduler.sv
// Floor position/enable owner for the pixel generator: seeds, scrolls,
// retires and spawns four floor slots, and counts retirements as score.
module floor_scheduler
    import floor_pkg::*;
#(
    parameter int SPEED        = 1,
    parameter int SPAWN_PERIOD = 60,
    parameter int SPAWN_Y      = 475,
    parameter int XMAX         = 600,
    parameter int INIT_X       = 300,
    parameter int INIT_Y       = 400
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_tick,
    input  logic                  start,
    input  logic                  stop,
    output logic                  running,
    output logic [POS_W-1:0]      floor_pos_x0,
    output logic [POS_W-1:0]      floor_pos_x1,
    output logic [POS_W-1:0]      floor_pos_x2,
    output logic [POS_W-1:0]      floor_pos_x3,
    output logic [POS_W-1:0]      floor_pos_y0,
    output logic [POS_W-1:0]      floor_pos_y1,
    output logic [POS_W-1:0]      floor_pos_y2,
    output logic [POS_W-1:0]      floor_pos_y3,
    output logic [NUM_FLOORS-1:0] enable,
    output logic [9:0]            score
);

    localparam int CNT_W = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SPAWN_PERIOD - 1);
    localparam logic [POS_W-1:0] SPEED_V   = POS_W'(SPEED);
    localparam logic [POS_W-1:0] SPAWN_Y_V = POS_W'(SPAWN_Y);
    localparam logic [POS_W-1:0] INIT_X_V  = POS_W'(INIT_X);
    localparam logic [POS_W-1:0] INIT_Y_V  = POS_W'(INIT_Y);

    state_e                state_q, state_d;
    logic                  running_q, running_d;
    logic [NUM_FLOORS-1:0] en_q, en_d;
    logic [POS_W-1:0]      x_q [NUM_FLOORS];
    logic [POS_W-1:0]      x_d [NUM_FLOORS];
    logic [POS_W-1:0]      y_q [NUM_FLOORS];
    logic [POS_W-1:0]      y_d [NUM_FLOORS];
    logic [9:0]            score_q, score_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [POS_W-1:0]      spawn_x;
    logic [NUM_FLOORS-1:0] retire;
    logic                  spawn;
    logic [1:0]            free_idx;
    logic [10:0]           score_sum;

    floor_lfsr #(
        .XMAX(XMAX)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .spawn_x(spawn_x)
    );

    // Everything a tick needs is derived from pre-tick register values.
    always_comb begin
        retire = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            retire[i] = en_q[i] && (y_q[i] < SPEED_V);
        end
        spawn     = (cnt_q == CNT_LAST) && (en_q != '1);
        free_idx  = first_free(en_q);
        score_sum = {1'b0, score_q} + 11'(popcount4(retire));
    end

    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        x_d     = x_q;
        y_d     = y_q;
        score_d = score_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE, HALT: begin
                if (start) begin
                    state_d = RUN;
                    en_d    = 4'b0001;
                    for (int i = 0; i < NUM_FLOORS; i++) begin
                        x_d[i] = '0;
                        y_d[i] = '0;
                    end
                    x_d[0]  = INIT_X_V;
                    y_d[0]  = INIT_Y_V;
                    score_d = '0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = HALT;
                end else if (frame_tick) begin
                    for (int i = 0; i < NUM_FLOORS; i++) begin
                        if (retire[i]) begin
                            en_d[i] = 1'b0;
                        end else if (en_q[i]) begin
                            y_d[i] = y_q[i] - SPEED_V;
                        end
                    end
                    if (spawn) begin
                        en_d[free_idx] = 1'b1;
                        x_d[free_idx]  = spawn_x;
                        y_d[free_idx]  = SPAWN_Y_V;
                        cnt_d          = '0;
                    end else if (cnt_q != CNT_LAST) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    score_d = score_sum[10] ? 10'h3FF : score_sum[9:0];
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign running_d = (state_d == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
            en_q      <= '0;
            score_q   <= '0;
            cnt_q     <= '0;
            for (int i = 0; i < NUM_FLOORS; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            running_q <= running_d;
            en_q      <= en_d;
            score_q   <= score_d;
            cnt_q     <= cnt_d;
            for (int i = 0; i < NUM_FLOORS; i++) begin
                x_q[i] <= x_d[i];
                y_q[i] <= y_d[i];
            end
        end
    end

    assign running      = running_q;
    assign enable       = en_q;
    assign score        = score_q;
    assign floor_pos_x0 = x_q[0];
    assign floor_pos_x1 = x_q[1];
    assign floor_pos_x2 = x_q[2];
    assign floor_pos_x3 = x_q[3];
    assign floor_pos_y0 = y_q[0];
    assign floor_pos_y1 = y_q[1];
    assign floor_pos_y2 = y_q[2];
    assign floor_pos_y3 = y_q[3];

endmodule
